// File: rtl/kernel_mhsa_mul_arbiter_if.sv
// Bus bundle for kernel_mhsa_mul_arbiter: requester side, shared multiplier side and response side.
// master = requesters + multiplier + response consumer; slave = the arbiter.
interface kernel_mhsa_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 80,
  parameter int B_W     = 24,
  parameter int P_W     = 80,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     req_ready;

  logic [A_W-1:0]         mul_din0;
  logic [B_W-1:0]         mul_din1;
  logic                   mul_ce;
  logic [P_W-1:0]         mul_dout;

  logic [NUM_REQ-1:0]     rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_data;
  logic                   rsp_ready;

  modport master (
    output req_valid, req_a, req_b, mul_dout, rsp_ready,
    input  req_ready, mul_din0, mul_din1, mul_ce, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_dout, rsp_ready,
    output req_ready, mul_din0, mul_din1, mul_ce, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/kernel_mhsa_mul_arbiter.sv
// Round-robin arbiter sharing one ce-gated pipelined multiplier; owner tags ride alongside the pipe.
// Optional perf counters (perf_busy_o/perf_stall_o/perf_clr_i) under `define KERNEL_MHSA_MUL_ARB_PERF_EN.
module kernel_mhsa_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 80,
  parameter int B_W     = 24,
  parameter int P_W     = 80,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  kernel_mhsa_mul_arbiter_if.slave bus
`ifdef KERNEL_MHSA_MUL_ARB_PERF_EN
  ,
  input  logic                    perf_clr_i,
  output logic [31:0]             perf_busy_o,
  output logic [31:0]             perf_stall_o
`endif
);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  tag_t            tag_q [MUL_LAT];
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic            head_v;
  logic            adv;
  logic            found;
  logic            grant_any;
  logic [ID_W-1:0] winner;

  // The whole pipe (multiplier registers and tags) moves only when the head can leave.
  assign head_v     = tag_q[MUL_LAT-1].v;
  assign adv        = !head_v || bus.rsp_ready;
  assign bus.mul_ce = adv;

  // Grant is also masked while reset is held, so nothing is offered to requesters then.
  assign grant_any  = adv && found && reset;

  // NOTE: every variable written in an always_comb gets a default first, so no latch can form.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      idx = sum[ID_W-1:0];
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.mul_din0  = '0;
    bus.mul_din1  = '0;
    if (grant_any) begin
      bus.req_ready = NUM_REQ'(1) << winner;
      bus.mul_din0  = bus.req_a[winner*A_W +: A_W];
      bus.mul_din1  = bus.req_b[winner*B_W +: B_W];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  // NOTE: the tag array is reset, unlike a data memory: its valid bits decide what gets returned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else if (adv) begin
      rr_ptr_q <= rr_ptr_d;
      tag_q[0] <= tag_t'{v: grant_any, id: winner};
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (head_v) begin
      bus.rsp_valid = NUM_REQ'(1) << tag_q[MUL_LAT-1].id;
    end
  end

  assign bus.rsp_id   = tag_q[MUL_LAT-1].id;
  assign bus.rsp_data = bus.mul_dout;

`ifdef KERNEL_MHSA_MUL_ARB_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;

  // Clear takes priority over counting; both counters stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (perf_clr_i) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (grant_any && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (head_v && !bus.rsp_ready && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
